// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: valid/ready byte writes, 5-8 data bits,
// none/odd/even parity, 1/2 stop bits, four selectable baud rates.
module uart_tx_buffered #(
    parameter  int CLK_HZ     = 50_000_000,
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    input  logic [1:0]       baud_rate,
    input  logic [1:0]       data_length,
    input  logic [1:0]       parity_type,
    input  logic             stop_bits,
    output logic             data_out,
    output logic             tx_active,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_empty,
    output logic             fifo_full
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DIV_W = $clog2(CLK_HZ / 2400 + 1);

    localparam logic [DIV_W-1:0] DIV_2400  = DIV_W'(CLK_HZ / 2400);
    localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(CLK_HZ / 4800);
    localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(CLK_HZ / 9600);
    localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(CLK_HZ / 19200);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // FIFO storage and pointers
    logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       push, pop;

    // Transmitter state and per-frame configuration latched at pop
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       baud_q, baud_d, len_q, len_d, par_q, par_d;
    logic             stop_q, stop_d;
    logic             line_q, line_d, active_q, active_d, done_q, done_d;

    logic [DIV_W-1:0] div_last;
    logic             bit_tick;
    logic [2:0]       last_data;
    logic [7:0]       data_mask;
    logic             par_en, par_bit;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_ready   = ~fifo_full;
    assign fifo_count = count_q;
    assign data_out   = line_q;
    assign tx_active  = active_q;
    assign tx_done    = done_q;

    assign push = wr_valid & ~fifo_full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        div_last = DIV_2400 - DIV_W'(1);
        case (baud_q)
            2'b00:   div_last = DIV_2400 - DIV_W'(1);
            2'b01:   div_last = DIV_4800 - DIV_W'(1);
            2'b10:   div_last = DIV_9600 - DIV_W'(1);
            default: div_last = DIV_19200 - DIV_W'(1);
        endcase
    end

    assign bit_tick  = (div_cnt_q == div_last);
    assign last_data = 3'd4 + {1'b0, len_q};
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);

    // Only the bits actually sent contribute to parity
    always_comb begin
        data_mask = 8'hFF;
        case (len_q)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
        par_bit = (^(data_q & data_mask)) ^ (par_q == 2'b01);
    end

    // Line outputs are registered, so they trail the state by one clock
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        baud_d    = baud_q;
        len_d     = len_q;
        par_d     = par_q;
        stop_d    = stop_q;
        pop       = 1'b0;
        line_d    = 1'b1;
        active_d  = 1'b0;
        done_d    = 1'b0;

        if (state_q != S_IDLE) begin
            active_d  = 1'b1;
            div_cnt_d = bit_tick ? '0 : div_cnt_q + DIV_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    data_d    = mem_q[rd_ptr_q];
                    baud_d    = baud_rate;
                    len_d     = data_length;
                    par_d     = parity_type;
                    stop_d    = stop_bits;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                line_d = 1'b0;
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                line_d = data_q[bit_cnt_q];
                if (bit_tick) begin
                    if (bit_cnt_q == last_data) begin
                        bit_cnt_d = '0;
                        state_d   = par_en ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                line_d = par_bit;
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                line_d = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt_q == {2'b00, stop_q}) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            baud_q    <= '0;
            len_q     <= '0;
            par_q     <= '0;
            stop_q    <= 1'b0;
            line_q    <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            baud_q    <= baud_d;
            len_q     <= len_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            line_q    <= line_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line monitor checks every frame cycle-by-cycle
// against expected frames queued when each byte is written.
module tb_uart_tx_buffered;
    localparam int CLK_HZ     = 96_000;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic             clock = 1'b0;
    logic             rst_n;
    logic             wr_valid, wr_ready, stop_bits;
    logic [7:0]       wr_data;
    logic [1:0]       baud_rate, data_length, parity_type;
    logic             data_out, tx_active, tx_done, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;

    uart_tx_buffered #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .baud_rate(baud_rate), .data_length(data_length),
        .parity_type(parity_type), .stop_bits(stop_bits), .data_out(data_out),
        .tx_active(tx_active), .tx_done(tx_done), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [1:0] baud, len, par;
        logic       stop;
        string      line;   // expected line levels, first bit leftmost
    } vec_t;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    int     checks = 0, failures = 0;
    frame_t sb[$];
    int     gaps[$];
    bit     in_frame = 1'b0;
    int     cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input logic [1:0] b);
        case (b)
            2'b00:   return CLK_HZ / 2400;
            2'b01:   return CLK_HZ / 4800;
            2'b10:   return CLK_HZ / 9600;
            default: return CLK_HZ / 19200;
        endcase
    endfunction

    function automatic frame_t str2frame(input string s, input logic [1:0] b);
        frame_t f;
        f.bits  = '1;
        f.nbits = s.len();
        f.div   = div_of(b);
        for (int i = 0; i < s.len(); i++) f.bits[i] = (s.getc(i) == 8'h31);
        return f;
    endfunction

    function automatic frame_t model(input logic [7:0] d, input logic [1:0] b,
                                     input logic [1:0] l, input logic [1:0] p,
                                     input logic s);
        frame_t f;
        int n = 5 + int'(l);
        int ones = 0;
        int k = 1;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i];
            ones      = ones + int'(d[i]);
            k         = k + 1;
        end
        if (p == 2'b01) begin f.bits[k] = (ones % 2 == 0); k = k + 1; end
        if (p == 2'b10) begin f.bits[k] = (ones % 2 == 1); k = k + 1; end
        k = k + (s ? 2 : 1);
        f.nbits = k;
        f.div   = div_of(b);
        return f;
    endfunction

    // Line monitor: every cycle of a frame is compared with the expected level
    initial begin : monitor
        frame_t f;
        int     last_end = 0;
        int     berr, derr, len;
        bit     aborted;
        forever begin
            @(negedge clock);
            if (rst_n === 1'b1 && data_out === 1'b0) begin
                chk("frame_expected", sb.size() != 0, 1);
                if (sb.size() == 0) begin
                    for (int w = 0; w < 2000 && data_out === 1'b0; w++) @(negedge clock);
                end else begin
                    f        = sb.pop_front();
                    in_frame = 1'b1;
                    gaps.push_back(cyc - last_end - 1);
                    len      = f.nbits * f.div;
                    berr     = 0;
                    derr     = 0;
                    aborted  = 1'b0;
                    for (int c = 0; c < len; c++) begin
                        if (c > 0) @(negedge clock);
                        if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                        if (data_out !== f.bits[c / f.div] || tx_active !== 1'b1) berr++;
                        if (tx_done !== (c == len - 1)) derr++;
                    end
                    if (!aborted) begin
                        chk("frame_bits", berr, 0);
                        chk("tx_done_pos", derr, 0);
                        last_end = cyc;
                    end
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic cfg(input logic [1:0] b, input logic [1:0] l,
                       input logic [1:0] p, input logic s);
        baud_rate = b; data_length = l; parity_type = p; stop_bits = s;
    endtask

    task automatic wr(input logic [7:0] d, output logic acc);
        @(negedge clock);
        wr_valid = 1'b1;
        wr_data  = d;
        #1 acc = wr_ready;
    endtask

    task automatic wr_end();
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || in_frame) && n < budget) begin
            @(negedge clock); #1; n++;
        end
        chk(name, (sb.size() == 0 && !in_frame), 1);
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic wait_low(input int budget, input string name);
        int n = 0;
        while (data_out !== 1'b0 && n < budget) begin
            @(negedge clock); #1; n++;
        end
        chk(name, data_out, 0);
    endtask

    vec_t vecs[8];
    logic acc;
    int   bad;

    initial begin
        vecs[0] = '{8'h74, 2'b10, 2'b11, 2'b01, 1'b0, "00010111011"};
        vecs[1] = '{8'hF5, 2'b11, 2'b00, 2'b10, 1'b1, "010101111"};
        vecs[2] = '{8'h00, 2'b01, 2'b10, 2'b00, 1'b0, "000000001"};
        vecs[3] = '{8'hFF, 2'b00, 2'b01, 2'b01, 1'b1, "0111111111"};
        vecs[4] = '{8'h3C, 2'b11, 2'b11, 2'b10, 1'b0, "00011110001"};
        vecs[5] = '{8'h5A, 2'b10, 2'b01, 2'b11, 1'b0, "00101101"};
        vecs[6] = '{8'hE0, 2'b11, 2'b00, 2'b01, 1'b0, "00000011"};
        vecs[7] = '{8'h81, 2'b01, 2'b11, 2'b10, 1'b1, "010000001011"};

        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0;
        cfg(2'b10, 2'b11, 2'b00, 1'b0);

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_data_out", data_out, 1);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fifo_count", fifo_count, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Write-to-line latency at 9600/8/odd/1
        cfg(vecs[0].baud, vecs[0].len, vecs[0].par, vecs[0].stop);
        wr(vecs[0].data, acc);
        chk("lat_acc", acc, 1);
        sb.push_back(str2frame(vecs[0].line, vecs[0].baud));
        wr_end(); #1;
        chk("lat_k_empty", fifo_empty, 0);
        chk("lat_k_count", fifo_count, 1);
        chk("lat_k_line", data_out, 1);
        @(negedge clock); #1;
        chk("lat_k1_empty", fifo_empty, 1);
        chk("lat_k1_line", data_out, 1);
        @(negedge clock); #1;
        chk("lat_k2_line", data_out, 0);
        chk("lat_k2_active", tx_active, 1);
        wait_drain(500, "lat_drain");

        // Table of single frames
        foreach (vecs[i]) begin
            cfg(vecs[i].baud, vecs[i].len, vecs[i].par, vecs[i].stop);
            wr(vecs[i].data, acc);
            chk("vec_acc", acc, 1);
            sb.push_back(str2frame(vecs[i].line, vecs[i].baud));
            wr_end();
            wait_drain(1000, "vec_drain");
            chk("vec_empty", fifo_empty, 1);
            chk("vec_active_idle", tx_active, 0);
        end

        // Fill the FIFO behind a running frame, then back-to-back drain
        cfg(2'b11, 2'b11, 2'b00, 1'b0);
        gaps.delete();
        wr(8'hA5, acc);
        chk("fill_acc0", acc, 1);
        sb.push_back(model(8'hA5, 2'b11, 2'b11, 2'b00, 1'b0));
        for (int i = 1; i <= 9; i++) begin
            wr(8'(i * 37), acc);
            chk("fill_acc", acc, (i < 9));
            if (acc) sb.push_back(model(8'(i * 37), 2'b11, 2'b11, 2'b00, 1'b0));
            if (i == 9) begin
                chk("fill_full", fifo_full, 1);
                chk("fill_count", fifo_count, FIFO_DEPTH);
                chk("fill_wr_ready", wr_ready, 0);
            end
        end
        wr_end();
        wait_drain(2000, "fill_drain");
        chk("fill_frames", gaps.size(), 9);
        bad = 0;
        for (int j = 1; j < gaps.size(); j++) if (gaps[j] != 1) bad++;
        chk("fill_gaps", bad, 0);
        chk("fill_empty", fifo_empty, 1);

        // Config change mid-frame only affects the next frame
        cfg(2'b10, 2'b11, 2'b01, 1'b0);
        wr(8'h74, acc);
        sb.push_back(model(8'h74, 2'b10, 2'b11, 2'b01, 1'b0));
        wr(8'h3C, acc);
        chk("cfg_acc", acc, 1);
        sb.push_back(model(8'h3C, 2'b00, 2'b11, 2'b00, 1'b0));
        wr_end();
        wait_low(50, "cfg_start");
        repeat (35) @(negedge clock);
        #1 cfg(2'b00, 2'b11, 2'b00, 1'b0);
        wait_drain(1500, "cfg_drain");

        // Asynchronous reset in the middle of a frame with entries queued
        cfg(2'b10, 2'b11, 2'b00, 1'b0);
        wr(8'h00, acc);
        sb.push_back(model(8'h00, 2'b10, 2'b11, 2'b00, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            wr(8'(i * 17), acc);
            sb.push_back(model(8'(i * 17), 2'b10, 2'b11, 2'b00, 1'b0));
        end
        wr_end();
        wait_low(50, "rst_mid_start");
        repeat (35) @(negedge clock);
        #1;
        chk("rst_mid_count_pre", fifo_count, 4);
        chk("rst_mid_line_pre", data_out, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_line", data_out, 1);
        chk("rst_mid_active", tx_active, 0);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_empty", fifo_empty, 1);
        chk("rst_mid_done", tx_done, 0);
        sb.delete();
        repeat (3) @(negedge clock);
        #2 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock); #1;
            if (data_out !== 1'b1 || tx_done !== 1'b0 || tx_active !== 1'b0) bad++;
        end
        chk("rst_mid_idle_after", bad, 0);
        chk("rst_mid_count_after", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
